// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: access codes, bus size codes,
// FSM state encoding and small decode helpers.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    MEMOP_LW  = 3'd0,
    MEMOP_LH  = 3'd1,
    MEMOP_LHU = 3'd2,
    MEMOP_LB  = 3'd3,
    MEMOP_LBU = 3'd4,
    MEMOP_SW  = 3'd5,
    MEMOP_SH  = 3'd6,
    MEMOP_SB  = 3'd7
  } memop_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } dsize_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic isStore(input memop_e op);
    return (op == MEMOP_SW) || (op == MEMOP_SH) || (op == MEMOP_SB);
  endfunction

  function automatic dsize_e accessSize(input memop_e op);
    case (op)
      MEMOP_LW, MEMOP_SW:             return SIZE_WORD;
      MEMOP_LH, MEMOP_LHU, MEMOP_SH:  return SIZE_HALF;
      default:                        return SIZE_BYTE;
    endcase
  endfunction

  function automatic logic isMisaligned(input memop_e op, input logic [1:0] addrLow);
    case (accessSize(op))
      SIZE_WORD: return addrLow != 2'b00;
      SIZE_HALF: return addrLow[0];
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-side SRAM-like bus between the memory access unit (master) and memory (slave).
interface mem_access_unit_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Load lane selection and sign/zero extension of a raw 32-bit bus word.
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  memop,
  input  logic [1:0]  addrLow,
  input  logic [31:0] rawData,
  output logic [31:0] loadData
);

  memop_e             op;
  logic signed [7:0]  byteSel;
  logic signed [15:0] halfSel;
  logic signed [31:0] byteSext;
  logic signed [31:0] halfSext;

  assign op = memop_e'(memop);

  always_comb begin
    byteSel = rawData[7:0];
    case (addrLow)
      2'd0:    byteSel = rawData[7:0];
      2'd1:    byteSel = rawData[15:8];
      2'd2:    byteSel = rawData[23:16];
      default: byteSel = rawData[31:24];
    endcase
  end

  assign halfSel  = addrLow[1] ? rawData[31:16] : rawData[15:0];
  // Signed-to-signed assignment widens with sign replication.
  assign byteSext = byteSel;
  assign halfSext = halfSel;

  always_comb begin
    loadData = rawData;
    case (op)
      MEMOP_LB:  loadData = byteSext;
      MEMOP_LBU: loadData = {24'd0, byteSel};
      MEMOP_LH:  loadData = halfSext;
      MEMOP_LHU: loadData = {16'd0, halfSel};
      default:   loadData = rawData;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: drives the data bus handshake, stalls the pipeline
// while an access is outstanding and returns extended load data in DONE.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      memenM,
  input  logic [2:0]                memopM,
  input  logic [31:0]               aluoutM,
  input  logic [31:0]               writedataM,
  output logic [31:0]               readdataM,
  output logic                      stallM,
  output logic                      adelM,
  output logic                      adesM,
  mem_access_unit_if.master         bus
);

  memop_e      op;
  logic        storeOp;
  logic        misaligned;
  logic        accessGo;
  logic        capture;
  logic [31:0] loadData;
  state_e      state;
  state_e      stateNext;
  logic [31:0] capData_p1;

  assign op         = memop_e'(memopM);
  assign storeOp    = isStore(op);
  assign misaligned = isMisaligned(op, aluoutM[1:0]);
  // Reset masks the request so nothing leaks onto the bus while rst is high.
  assign accessGo   = memenM & ~misaligned & ~rst;

  assign adelM = memenM & misaligned & ~storeOp;
  assign adesM = memenM & misaligned &  storeOp;

  assign bus.data_addr = aluoutM;
  assign bus.data_wr   = storeOp;
  assign bus.data_size = accessSize(op);

  always_comb begin
    bus.data_wdata = writedataM;
    case (op)
      MEMOP_SB: bus.data_wdata = {4{writedataM[7:0]}};
      MEMOP_SH: bus.data_wdata = {2{writedataM[15:0]}};
      default:  bus.data_wdata = writedataM;
    endcase
  end

  always_comb begin
    capture = 1'b0;
    case (state)
      ST_IDLE, ST_REQ: capture = accessGo & bus.data_addr_ok & bus.data_data_ok;
      ST_WAIT:         capture = bus.data_data_ok;
      default:         capture = 1'b0;
    endcase
  end

  // ---- state / capture register stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      capData_p1 <= 32'd0;
    end else begin
      state <= stateNext;
      if (capture) capData_p1 <= bus.data_rdata;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE, ST_REQ: begin
        if (!accessGo)                                 stateNext = ST_IDLE;
        else if (bus.data_addr_ok && bus.data_data_ok) stateNext = ST_DONE;
        else if (bus.data_addr_ok)                     stateNext = ST_WAIT;
        else                                           stateNext = ST_REQ;
      end
      ST_WAIT: if (bus.data_data_ok) stateNext = ST_DONE;
      default: stateNext = ST_IDLE;
    endcase
  end

  load_extend u_load_extend (
    .memop    (memopM),
    .addrLow  (aluoutM[1:0]),
    .rawData  (capData_p1),
    .loadData (loadData)
  );

  always_comb begin
    bus.data_req = 1'b0;
    stallM       = 1'b0;
    readdataM    = 32'd0;
    case (state)
      ST_IDLE, ST_REQ: begin
        bus.data_req = accessGo;
        stallM       = accessGo;
      end
      ST_WAIT: stallM = accessGo;
      ST_DONE: readdataM = storeOp ? 32'd0 : loadData;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        memenM;
  logic [2:0]  memopM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        stallM;
  logic        adelM;
  logic        adesM;

  int vectors;
  int miscompares;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk        (clk),
    .rst        (rst),
    .memenM     (memenM),
    .memopM     (memopM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .stallM     (stallM),
    .adelM      (adelM),
    .adesM      (adesM),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleBus();
    memenM            = 1'b0;
    bus.data_addr_ok  = 1'b0;
    bus.data_data_ok  = 1'b0;
    bus.data_rdata    = 32'd0;
  endtask

  // Load with addr_ok and data_ok in the issue cycle; returns readdataM seen in DONE.
  task automatic quickLoad(input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, output logic [31:0] result);
    memenM = 1'b1; memopM = op; aluoutM = addr;
    bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = rdata;
    step();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    @(negedge clk);
    result = readdataM;
    step();
    memenM = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    memenM = 1'b1; memopM = 3'd0; aluoutM = 32'h100;
    @(negedge clk);
    vectors++; if (bus.data_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b expected 0", bus.data_req); end
    vectors++; if (stallM !== 1'b0) begin miscompares++; $display("FAIL rst_stall: got %b expected 0", stallM); end
    vectors++; if (readdataM !== 32'h0) begin miscompares++; $display("FAIL rst_rdata: got %h expected 00000000", readdataM); end
    memenM = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (bus.data_req !== 1'b0 || stallM !== 1'b0) begin miscompares++; $display("FAIL post_rst_idle: got req=%b stall=%b expected 0/0", bus.data_req, stallM); end
    vectors++; if (readdataM !== 32'h0) begin miscompares++; $display("FAIL post_rst_rdata: got %h expected 00000000", readdataM); end
    step();
  endtask

  task automatic test_load_word();
    memenM = 1'b1; memopM = 3'd0; aluoutM = 32'h100; bus.data_addr_ok = 1'b1;
    @(negedge clk);
    vectors++; if (stallM !== 1'b1 || bus.data_req !== 1'b1) begin miscompares++; $display("FAIL lw_c0: got stall=%b req=%b expected 1/1", stallM, bus.data_req); end
    vectors++; if (bus.data_wr !== 1'b0 || bus.data_size !== 2'd2 || bus.data_addr !== 32'h100) begin miscompares++; $display("FAIL lw_c0_bus: got wr=%b size=%0d addr=%h expected 0/2/00000100", bus.data_wr, bus.data_size, bus.data_addr); end
    step();
    bus.data_addr_ok = 1'b0;
    @(negedge clk);
    vectors++; if (stallM !== 1'b1 || bus.data_req !== 1'b0) begin miscompares++; $display("FAIL lw_c1: got stall=%b req=%b expected 1/0", stallM, bus.data_req); end
    step();
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'hDEADBEEF;
    @(negedge clk);
    vectors++; if (stallM !== 1'b1) begin miscompares++; $display("FAIL lw_c2_stall: got %b expected 1", stallM); end
    step();
    bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    @(negedge clk);
    vectors++; if (readdataM !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lw_c3_rdata: got %h expected deadbeef", readdataM); end
    vectors++; if (stallM !== 1'b0) begin miscompares++; $display("FAIL lw_c3_stall: got %b expected 0", stallM); end
    step();
    memenM = 1'b0;
    @(negedge clk);
    vectors++; if (readdataM !== 32'h0 || stallM !== 1'b0) begin miscompares++; $display("FAIL lw_after: got rdata=%h stall=%b expected 00000000/0", readdataM, stallM); end
    step();
  endtask

  task automatic test_load_extend();
    logic [31:0] r;
    quickLoad(3'd3, 32'h103, 32'h80FFFF7F, r);
    vectors++; if (r !== 32'hFFFFFF80) begin miscompares++; $display("FAIL lb_103: got %h expected ffffff80", r); end
    quickLoad(3'd4, 32'h103, 32'h80FFFF7F, r);
    vectors++; if (r !== 32'h00000080) begin miscompares++; $display("FAIL lbu_103: got %h expected 00000080", r); end
    quickLoad(3'd1, 32'h102, 32'h80FFFF7F, r);
    vectors++; if (r !== 32'hFFFF80FF) begin miscompares++; $display("FAIL lh_102: got %h expected ffff80ff", r); end
    quickLoad(3'd2, 32'h102, 32'h80FFFF7F, r);
    vectors++; if (r !== 32'h000080FF) begin miscompares++; $display("FAIL lhu_102: got %h expected 000080ff", r); end
    quickLoad(3'd3, 32'h100, 32'h80FFFF7F, r);
    vectors++; if (r !== 32'h0000007F) begin miscompares++; $display("FAIL lb_100: got %h expected 0000007f", r); end
    quickLoad(3'd1, 32'h100, 32'h80FFFF7F, r);
    vectors++; if (r !== 32'hFFFFFF7F) begin miscompares++; $display("FAIL lh_100: got %h expected ffffff7f", r); end
    quickLoad(3'd3, 32'h102, 32'h12A45678, r);
    vectors++; if (r !== 32'hFFFFFFA4) begin miscompares++; $display("FAIL lb_102: got %h expected ffffffa4", r); end
    quickLoad(3'd4, 32'h101, 32'h80FFFF7F, r);
    vectors++; if (r !== 32'h000000FF) begin miscompares++; $display("FAIL lbu_101: got %h expected 000000ff", r); end
  endtask

  task automatic test_store();
    memenM = 1'b1; memopM = 3'd7; aluoutM = 32'h101; writedataM = 32'h12345678;
    bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    vectors++; if (bus.data_req !== 1'b1 || bus.data_wr !== 1'b1 || bus.data_size !== 2'd0) begin miscompares++; $display("FAIL sb_ctrl: got req=%b wr=%b size=%0d expected 1/1/0", bus.data_req, bus.data_wr, bus.data_size); end
    vectors++; if (bus.data_wdata !== 32'h78787878) begin miscompares++; $display("FAIL sb_wdata: got %h expected 78787878", bus.data_wdata); end
    vectors++; if (bus.data_addr !== 32'h101) begin miscompares++; $display("FAIL sb_addr: got %h expected 00000101", bus.data_addr); end
    step();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    @(negedge clk);
    vectors++; if (readdataM !== 32'h0 || stallM !== 1'b0) begin miscompares++; $display("FAIL sb_done: got rdata=%h stall=%b expected 00000000/0", readdataM, stallM); end
    step();
    memopM = 3'd6; aluoutM = 32'h102;
    bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1;
    @(negedge clk);
    vectors++; if (bus.data_wdata !== 32'h56785678 || bus.data_size !== 2'd1 || bus.data_wr !== 1'b1) begin miscompares++; $display("FAIL sh_bus: got wdata=%h size=%0d wr=%b expected 56785678/1/1", bus.data_wdata, bus.data_size, bus.data_wr); end
    step();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    step();
    memopM = 3'd5; aluoutM = 32'h104; writedataM = 32'hCAFEF00D;
    bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1;
    @(negedge clk);
    vectors++; if (bus.data_wdata !== 32'hCAFEF00D || bus.data_size !== 2'd2) begin miscompares++; $display("FAIL sw_bus: got wdata=%h size=%0d expected cafef00d/2", bus.data_wdata, bus.data_size); end
    step();
    idleBus();
    step();
  endtask

  task automatic test_misaligned();
    memenM = 1'b1; memopM = 3'd0; aluoutM = 32'h102; bus.data_addr_ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++; if (adelM !== 1'b1 || adesM !== 1'b0) begin miscompares++; $display("FAIL lw_mis_flags c%0d: got adel=%b ades=%b expected 1/0", c, adelM, adesM); end
      vectors++; if (bus.data_req !== 1'b0 || stallM !== 1'b0) begin miscompares++; $display("FAIL lw_mis_req c%0d: got req=%b stall=%b expected 0/0", c, bus.data_req, stallM); end
      step();
    end
    memopM = 3'd6; aluoutM = 32'h101;
    @(negedge clk);
    vectors++; if (adesM !== 1'b1 || adelM !== 1'b0 || bus.data_req !== 1'b0) begin miscompares++; $display("FAIL sh_mis: got ades=%b adel=%b req=%b expected 1/0/0", adesM, adelM, bus.data_req); end
    memopM = 3'd2; aluoutM = 32'h103;
    #1;
    vectors++; if (adelM !== 1'b1) begin miscompares++; $display("FAIL lhu_mis: got adel=%b expected 1", adelM); end
    memenM = 1'b0;
    #1;
    vectors++; if (adelM !== 1'b0) begin miscompares++; $display("FAIL mis_memen0: got adel=%b expected 0", adelM); end
    step();
    bus.data_addr_ok = 1'b0;
    step();
  endtask

  task automatic test_addr_wait();
    memenM = 1'b1; memopM = 3'd0; aluoutM = 32'h208; writedataM = 32'h11223344;
    bus.data_rdata = 32'h99999999;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++; if (bus.data_req !== 1'b1 || stallM !== 1'b1) begin miscompares++; $display("FAIL wait_req c%0d: got req=%b stall=%b expected 1/1", c, bus.data_req, stallM); end
      vectors++; if (bus.data_addr !== 32'h208 || bus.data_size !== 2'd2 || bus.data_wr !== 1'b0) begin miscompares++; $display("FAIL wait_bus c%0d: got addr=%h size=%0d wr=%b expected 00000208/2/0", c, bus.data_addr, bus.data_size, bus.data_wr); end
      step();
    end
    bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h0BADF00D;
    @(negedge clk);
    vectors++; if (bus.data_req !== 1'b1) begin miscompares++; $display("FAIL wait_ok_req: got %b expected 1", bus.data_req); end
    step();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    @(negedge clk);
    vectors++; if (readdataM !== 32'h0BADF00D || stallM !== 1'b0) begin miscompares++; $display("FAIL wait_done: got rdata=%h stall=%b expected 0badf00d/0", readdataM, stallM); end
    step();
    memenM = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    memenM = 1'b1; memopM = 3'd0; aluoutM = 32'h300; bus.data_addr_ok = 1'b1;
    step();
    bus.data_addr_ok = 1'b0;
    @(negedge clk);
    vectors++; if (stallM !== 1'b1) begin miscompares++; $display("FAIL mid_wait_stall: got %b expected 1", stallM); end
    #1 rst = 1'b1;
    #1;
    vectors++; if (stallM !== 1'b0 || readdataM !== 32'h0 || bus.data_req !== 1'b0) begin miscompares++; $display("FAIL mid_rst: got stall=%b rdata=%h req=%b expected 0/00000000/0", stallM, readdataM, bus.data_req); end
    memenM = 1'b0;
    step();
    rst = 1'b0;
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'h55555555;
    @(negedge clk);
    vectors++; if (stallM !== 1'b0 || bus.data_req !== 1'b0) begin miscompares++; $display("FAIL late_ok_ctrl: got stall=%b req=%b expected 0/0", stallM, bus.data_req); end
    step();
    bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    @(negedge clk);
    vectors++; if (readdataM !== 32'h0) begin miscompares++; $display("FAIL late_ok_rdata: got %h expected 00000000", readdataM); end
    step();
    quickLoad(3'd4, 32'h302, 32'h00C30000, r);
    vectors++; if (r !== 32'h000000C3) begin miscompares++; $display("FAIL post_rst_lbu: got %h expected 000000c3", r); end
  endtask

  task automatic test_back_to_back();
    memenM = 1'b1; memopM = 3'd0; aluoutM = 32'h400;
    bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hA5A5_0001;
    step();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    @(negedge clk);
    vectors++; if (readdataM !== 32'hA5A50001) begin miscompares++; $display("FAIL b2b_first: got %h expected a5a50001", readdataM); end
    step();
    memopM = 3'd4; aluoutM = 32'h401;
    bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h0000AB00;
    @(negedge clk);
    vectors++; if (bus.data_req !== 1'b1 || stallM !== 1'b1 || bus.data_size !== 2'd0) begin miscompares++; $display("FAIL b2b_second_req: got req=%b stall=%b size=%0d expected 1/1/0", bus.data_req, stallM, bus.data_size); end
    step();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    @(negedge clk);
    vectors++; if (readdataM !== 32'h000000AB) begin miscompares++; $display("FAIL b2b_second: got %h expected 000000ab", readdataM); end
    step();
    memenM = 1'b0;
    step();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    memopM = 3'd0; aluoutM = 32'h0; writedataM = 32'h0;
    idleBus();
    step();
    test_reset();
    test_load_word();
    test_load_extend();
    test_store();
    test_misaligned();
    test_addr_wait();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters: none; all widths fixed at 32-bit address/data.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 memenM  in  1  memory-stage instruction performs a load/store.
REQ-005 memopM  in  3  access type, encoded per REQ-012.
REQ-006 aluoutM  in  32  effective byte address.
REQ-007 writedataM  in  32  store data, unaligned in bits [7:0]/[15:0]/[31:0].
REQ-008 readdataM  out  32  extended load result for writeback.
REQ-009 stallM  out  1  freezes F/D/E/M pipeline registers while high.
REQ-010 adelM / adesM  out  1 each  misaligned load / misaligned store flags.
REQ-011 Bus ports: data_req out 1, data_wr out 1, data_size out 2 (0=byte, 1=half, 2=word), data_addr out 32, data_wdata out 32, data_addr_ok in 1, data_data_ok in 1, data_rdata in 32.

Function
REQ-012 memopM encoding: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB; codes 5-7 are stores.
REQ-013 Misaligned: LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]=1; adelM/adesM assert combinationally while memenM=1; no bus request is issued; stallM=0.
REQ-014 FSM states: IDLE, REQ, WAIT, DONE.
REQ-015 IDLE: if memenM and aligned, data_req=1 in the same cycle; addr_ok&data_ok -> DONE; addr_ok only -> WAIT; otherwise -> REQ.
REQ-016 REQ: data_req=1 with all bus outputs held stable; transition rules as in REQ-015.
REQ-017 WAIT: data_req=0; data_ok -> DONE; otherwise stay.
REQ-018 DONE: no request; stallM=0; readdataM valid; -> IDLE unconditionally.
REQ-019 On the data_ok cycle, data_rdata is captured into an internal register; readdataM is driven from that register in DONE.
REQ-020 stallM = memenM & aligned & (state!=DONE).
REQ-021 data_addr = aluoutM; data_wr=1 for codes 5-7; data_size follows the access width.
REQ-022 data_wdata: SB replicates byte to all 4 lanes; SH replicates half to both lanes; SW passes through unchanged.
REQ-023 Loads select the lane by addr[1:0] (half by addr[1]); LB/LH sign-extend; LBU/LHU zero-extend.
REQ-024 Stores: readdataM=0 in DONE.
REQ-025 memenM=0 in IDLE: data_req=0, stallM=0, readdataM=0.

Reset
REQ-026 rst forces state=IDLE and the captured-data register to 0 immediately, including mid-transaction.
REQ-027 During and after reset: data_req=0, stallM=0, readdataM=0 until a new access starts.

Structure
REQ-028 Shared package holds the memop codes, data_size codes, and FSM state encoding.
REQ-029 One sub-module, load_extend, performs the combinational lane select and extension of REQ-023.

Verification
REQ-030 LW at 0x100; addr_ok in cycle 0, data_ok in cycle 2 with rdata 0xDEADBEEF: stallM high cycles 0-2; readdataM=0xDEADBEEF in cycle 3; stallM=0 in cycle 3.
REQ-031 LB at 0x103 with rdata 0x80FF_FF7F returns 0xFFFFFF80; LBU at the same address returns 0x00000080; LH at 0x102 returns 0xFFFF80FF.
REQ-032 SB at 0x101 with writedataM 0x12345678: data_wr=1, data_size=0, data_wdata=0x78787878, addr=0x101.
REQ-033 LW at 0x102: adelM=1, data_req never asserted, stallM=0; SH at 0x101: adesM=1.
REQ-034 data_addr_ok withheld 3 cycles: data_req and all bus outputs stable throughout; addr_ok and data_ok in the same cycle -> DONE next cycle.
REQ-035 rst asserted in WAIT: state returns to IDLE, stallM=0, readdataM=0 immediately; a late data_ok after reset has no effect.
